// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq
//   Program-counter sequencer and instruction-fetch front end. Holds a
//   word-index PC and issues fetches over a req/ack handshake. Each fetched
//   word lands in a one-entry output slot with a valid/ready handshake toward
//   decode. Branch redirects and halt/resume control steer the sequence.
//
// Optional feature macro: PC_WRAP_TRAP_EN
//   Defined   : a fetch ack at the last PC sets a sticky trap and holds the
//               PC there. The core halts once that instruction is consumed,
//               and resume is ignored while trap is set.
//   Undefined : the PC wraps silently and trap is tied low.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  fetch request (FETCH state)
//   imem_addr    out  fetch address, always equal to pc_val
//   imem_ack     in   memory returns imem_rdata for imem_addr this cycle
//   imem_rdata   in   fetched word
//   instr        out  instruction held in the output slot
//   instr_pc     out  PC of instr
//   instr_valid  out  output slot full
//   instr_ready  in   decode consumes the slot when high with instr_valid
//   br_valid     in   single-cycle redirect request
//   br_target    in   redirect PC
//   halt_req     in   level; stop fetching at the next instruction boundary
//   resume       in   single-cycle pulse; leave HALT
//   pc_val       out  current PC register
//   halted       out  high in HALT
//   trap         out  sticky PC-overflow trap (macro builds only)
//
// State  | meaning
// IDLE   | first cycle out of reset, nothing fetched yet
// FETCH  | imem_req high, waiting for imem_ack
// FULL   | output slot holds an instruction, waiting for instr_ready
// HALT   | fetching stopped until resume (or reset)

module pc_fetch_seq #(
    parameter int              PC_W     = 5,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_valid,
    input  logic [PC_W-1:0]    br_target,
    input  logic               halt_req,
    input  logic               resume,
    output logic [PC_W-1:0]    pc_val,
    output logic               halted,
    output logic               trap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            capture;
    logic            trap_active;

`ifdef PC_WRAP_TRAP_EN
    localparam logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}};
    logic trap_q;
    logic trap_set;
    assign trap        = trap_q;
    assign trap_active = trap_q;
`else
    assign trap        = 1'b0;
    assign trap_active = 1'b0;
`endif

    // The memory address is the PC itself; it only moves during a request
    // when a redirect lands.
    assign imem_addr = pc_val;

    // Next-state and datapath decisions. A redirect outranks every other
    // input in every state.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_val;
        capture   = 1'b0;
`ifdef PC_WRAP_TRAP_EN
        trap_set  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
                if (br_valid) begin
                    pc_nxt = br_target;
                end
            end
            S_FETCH: begin
                if (br_valid) begin
                    // Any data acked this cycle belongs to the old path.
                    pc_nxt = br_target;
                end else if (imem_ack) begin
                    capture   = 1'b1;
                    state_nxt = S_FULL;
`ifdef PC_WRAP_TRAP_EN
                    if (pc_val == PC_LAST) begin
                        trap_set = 1'b1;
                    end else begin
                        pc_nxt = pc_val + 1'b1;
                    end
`else
                    pc_nxt = pc_val + 1'b1;
`endif
                end else if (halt_req) begin
                    // Nothing is in flight, so the current address is simply
                    // refetched after resume.
                    state_nxt = S_HALT;
                end
            end
            S_FULL: begin
                if (br_valid) begin
                    pc_nxt    = br_target;
                    state_nxt = S_FETCH;
                end else if (instr_ready) begin
                    state_nxt = (halt_req || trap_active) ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (br_valid) begin
                    pc_nxt = br_target;
                end else if (resume && !trap_active) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with Moore outputs registered from the next state so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc_val      <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc_val      <= pc_nxt;
            imem_req    <= (state_nxt == S_FETCH);
            instr_valid <= (state_nxt == S_FULL);
            halted      <= (state_nxt == S_HALT);
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc_val;
            end
`ifdef PC_WRAP_TRAP_EN
            if (trap_set) begin
                trap_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
module tb_pc_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [4:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [4:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_valid;
    logic [4:0]  br_target;
    logic        halt_req;
    logic        resume;
    logic [4:0]  pc_val;
    logic        halted;
    logic        trap;

    logic [31:0] mem [32];
    assign imem_rdata = mem[imem_addr];

    int tests = 0;
    int fails = 0;

`ifdef PC_WRAP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    pc_fetch_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc_val      (pc_val),
        .halted      (halted),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic r, input logic b, input logic [4:0] t,
                         input logic h, input logic rs);
        imem_ack    = a;
        instr_ready = r;
        br_valid    = b;
        br_target   = t;
        halt_req    = h;
        resume      = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".pc"},    32'(pc_val), 32'd0);
        chk({tag, ".req"},   32'(imem_req), 32'd0);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".halted"},32'(halted), 32'd0);
        chk({tag, ".instr"}, instr, 32'd0);
        chk({tag, ".ipc"},   32'(instr_pc), 32'd0);
        chk({tag, ".trap"},  32'(trap), 32'd0);
    endtask

    // Behavioural reference: a handful of flags describing what the front end
    // is doing, advanced one clock at a time from the rules.
    bit          m_started, m_full, m_halted, m_trap;
    logic [4:0]  m_pc, m_ipc;
    logic [31:0] m_instr;

    function automatic void model_reset();
        m_started = 0; m_full = 0; m_halted = 0; m_trap = 0;
        m_pc = 5'd0; m_ipc = 5'd0; m_instr = 32'd0;
    endfunction

    function automatic void model_step(input bit a, input bit r, input bit b,
                                       input logic [4:0] t, input bit h, input bit rs);
        if (!m_started) begin
            m_started = 1;
            if (b) m_pc = t;
        end else if (m_halted) begin
            if (b) m_pc = t;
            else if (rs && !m_trap) m_halted = 0;
        end else if (m_full) begin
            if (b) begin
                m_pc = t;
                m_full = 0;
            end else if (r) begin
                m_full = 0;
                if (h || m_trap) m_halted = 1;
            end
        end else begin
            if (b) m_pc = t;
            else if (a) begin
                m_instr = mem[m_pc];
                m_ipc = m_pc;
                m_full = 1;
                if (TRAP_EN && m_pc == 5'd31) m_trap = 1;
                else m_pc = 5'((int'(m_pc) + 1) % 32);
            end else if (h) m_halted = 1;
        end
    endfunction

    typedef struct {
        logic       ack, ready, br;
        logic [4:0] tgt;
        logic       halt, res;
        logic       req, valid, hlt;
        logic [4:0] pc, ipc;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic a, input logic r, input logic b, input logic [4:0] t,
                        input logic h, input logic rs, input logic q, input logic v,
                        input logic hl, input logic [4:0] p, input logic [4:0] ip);
        vec_t e;
        e.ack = a; e.ready = r; e.br = b; e.tgt = t; e.halt = h; e.res = rs;
        e.req = q; e.valid = v; e.hlt = hl; e.pc = p; e.ipc = ip;
        tbl.push_back(e);
    endtask

    logic       r_ack, r_rdy, r_br, r_halt, r_res;
    logic [4:0] r_tgt;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);

        //   ack rdy br tgt  hlt res | req val hlt pc  ipc
        addv(1, 1, 0, 0,  0, 0,  1, 0, 0, 0,  0);
        addv(1, 1, 0, 0,  0, 0,  0, 1, 0, 1,  0);
        addv(1, 1, 0, 0,  0, 0,  1, 0, 0, 1,  0);
        addv(1, 1, 0, 0,  0, 0,  0, 1, 0, 2,  1);
        addv(1, 1, 0, 0,  0, 0,  1, 0, 0, 2,  0);
        addv(1, 1, 0, 0,  0, 0,  0, 1, 0, 3,  2);
        addv(1, 1, 0, 0,  0, 0,  1, 0, 0, 3,  0);
        addv(1, 1, 0, 0,  0, 0,  0, 1, 0, 4,  3);
        addv(1, 1, 0, 0,  0, 0,  1, 0, 0, 4,  0);
        addv(1, 1, 1, 20, 0, 0,  1, 0, 0, 20, 0);
        addv(1, 0, 0, 0,  0, 0,  0, 1, 0, 21, 20);
        for (int i = 0; i < 5; i++) addv(1, 0, 0, 0, 0, 0, 0, 1, 0, 21, 20);
        addv(1, 0, 0, 0,  1, 0,  0, 1, 0, 21, 20);
        addv(1, 1, 0, 0,  1, 0,  0, 0, 1, 21, 0);
        for (int i = 0; i < 3; i++) addv(1, 1, 0, 0, 0, 0, 0, 0, 1, 21, 0);
        addv(1, 1, 0, 0,  0, 1,  1, 0, 0, 21, 0);
        addv(1, 1, 0, 0,  0, 0,  0, 1, 0, 22, 21);
        addv(1, 1, 0, 0,  0, 1,  1, 0, 0, 22, 0);
        addv(0, 1, 0, 0,  1, 0,  0, 0, 1, 22, 0);
        addv(0, 1, 1, 9,  0, 1,  0, 0, 1, 9,  0);
        addv(1, 1, 0, 0,  0, 1,  1, 0, 0, 9,  0);
        addv(1, 1, 0, 0,  0, 0,  0, 1, 0, 10, 9);

        do_reset();
        check_reset("rst");
        foreach (tbl[i]) begin
            drive(tbl[i].ack, tbl[i].ready, tbl[i].br, tbl[i].tgt, tbl[i].halt, tbl[i].res);
            tick();
            chk($sformatf("v%0d.req", i),    32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("v%0d.valid", i),  32'(instr_valid), 32'(tbl[i].valid));
            chk($sformatf("v%0d.halted", i), 32'(halted), 32'(tbl[i].hlt));
            chk($sformatf("v%0d.pc", i),     32'(pc_val), 32'(tbl[i].pc));
            chk($sformatf("v%0d.addr", i),   32'(imem_addr), 32'(tbl[i].pc));
            if (tbl[i].valid) begin
                chk($sformatf("v%0d.ipc", i),   32'(instr_pc), 32'(tbl[i].ipc));
                chk($sformatf("v%0d.instr", i), instr, 32'hA000_0000 + 32'(tbl[i].ipc));
            end
        end

        // Run up to the last PC.
        do_reset();
        drive(1, 1, 1, 5'd30, 0, 0); tick();
        chk("wrap.pc30", 32'(pc_val), 32'd30);
        drive(1, 1, 0, 5'd0, 0, 0); tick();
        chk("wrap.ipc30", 32'(instr_pc), 32'd30);
        tick();
        chk("wrap.req31", 32'(imem_req), 32'd1);
        tick();
        chk("wrap.ipc31", 32'(instr_pc), 32'd31);
        chk("wrap.instr31", instr, 32'hA000_001F);
        chk("wrap.valid31", 32'(instr_valid), 32'd1);
`ifdef PC_WRAP_TRAP_EN
        chk("wrap.pc_hold", 32'(pc_val), 32'd31);
        chk("wrap.trap", 32'(trap), 32'd1);
        tick();
        chk("wrap.halted", 32'(halted), 32'd1);
        chk("wrap.req_off", 32'(imem_req), 32'd0);
        drive(1, 1, 0, 5'd0, 0, 1); tick();
        chk("wrap.resume_ign", 32'(halted), 32'd1);
        drive(1, 1, 1, 5'd5, 0, 0); tick();
        chk("wrap.br_pc", 32'(pc_val), 32'd5);
        chk("wrap.br_halted", 32'(halted), 32'd1);
        chk("wrap.trap_sticky", 32'(trap), 32'd1);
`else
        chk("wrap.pc0", 32'(pc_val), 32'd0);
        chk("wrap.trap0", 32'(trap), 32'd0);
        tick();
        chk("wrap.req0", 32'(imem_req), 32'd1);
        tick();
        chk("wrap.ipc0", 32'(instr_pc), 32'd0);
        chk("wrap.instr0", instr, 32'hA000_0000);
`endif

        // Asynchronous reset in the middle of a fetch.
        do_reset();
        drive(0, 1, 1, 5'd7, 0, 0); tick();
        drive(0, 1, 0, 5'd0, 0, 0); tick();
        chk("async.pre_req", 32'(imem_req), 32'd1);
        chk("async.pre_pc", 32'(pc_val), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");

        // Random traffic against the reference model.
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        r_halt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                do_reset();
                model_reset();
                check_reset($sformatf("rnd%0d", i));
            end
            r_ack = ($urandom_range(2) != 0);
            r_rdy = ($urandom_range(2) != 0);
            r_br  = ($urandom_range(9) == 0);
            r_tgt = ($urandom_range(3) == 0) ? 5'(30 + $urandom_range(1)) : 5'($urandom_range(31));
            if ($urandom_range(15) == 0) r_halt = ~r_halt;
            r_res = ($urandom_range(5) == 0);
            drive(r_ack, r_rdy, r_br, r_tgt, r_halt, r_res);
            model_step(r_ack, r_rdy, r_br, r_tgt, r_halt, r_res);
            tick();
            chk($sformatf("r%0d.req", i),    32'(imem_req), 32'(m_started && !m_full && !m_halted));
            chk($sformatf("r%0d.valid", i),  32'(instr_valid), 32'(m_full));
            chk($sformatf("r%0d.halted", i), 32'(halted), 32'(m_halted));
            chk($sformatf("r%0d.pc", i),     32'(pc_val), 32'(m_pc));
            chk($sformatf("r%0d.trap", i),   32'(trap), 32'(m_trap));
            if (m_full) begin
                chk($sformatf("r%0d.ipc", i),   32'(instr_pc), 32'(m_ipc));
                chk($sformatf("r%0d.instr", i), instr, m_instr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
